// File: rtl/pulse_train_gen_pkg.sv
// Shared types and helpers for the pulse train generator.
package pulse_train_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int unsigned MIN_LEN = 1;

    function automatic int unsigned eff_len(input int unsigned len);
        return (len < MIN_LEN) ? MIN_LEN : len;
    endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter with clear and a registered overflow pulse.
module sat_updown_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         dec_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o,
    output logic         full_o,
    output logic         ovf_o
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] cnt_q, cnt_d;
    logic         ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i) begin
            if (cnt_q == MAX) ovf_d = 1'b1;
            else              cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign count_o = cnt_q;
    assign full_o  = (cnt_q == MAX);
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/pulse_train_gen.sv
// Converts trigger pulses into timed high pulses with a minimum low gap,
// queueing triggers that arrive while a pulse train is in progress.
module pulse_train_gen
    import pulse_train_gen_pkg::*;
#(
    parameter int LEN_W  = 8,
    parameter int PEND_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              trig,
    input  logic [LEN_W-1:0]  high_len,
    input  logic [LEN_W-1:0]  gap_len,
    output logic              signal_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              done,
    output logic              overflow
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             so_q, so_d;
    logic             done_q, done_d;
    logic             start, consume;
    logic             inc, full_unused;
    logic [LEN_W-1:0] high_m1, gap_m1;

    assign high_m1 = LEN_W'(eff_len(32'(high_len)) - 1);
    assign gap_m1  = LEN_W'(eff_len(32'(gap_len)) - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        so_d    = so_q;
        done_d  = 1'b0;
        start   = 1'b0;
        consume = 1'b0;
        unique case (state_q)
            IDLE: start = en && trig;
            HIGH: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    so_d    = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = gap_m1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    // A trigger landing exactly at gap expiry with an empty
                    // queue starts directly instead of stranding in IDLE.
                    consume = en && (pending != '0);
                    start   = consume || (en && trig);
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (start) begin
            state_d = HIGH;
            so_d    = 1'b1;
            cnt_d   = high_m1;
        end
    end

    assign inc = en && trig && !(start && !consume);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            so_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            so_q    <= so_d;
            done_q  <= done_d;
        end
    end

    sat_updown_cnt #(.W(PEND_W)) u_pend (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (inc),
        .dec_i   (consume),
        .clr_i   (!en),
        .count_o (pending),
        .full_o  (full_unused),
        .ovf_o   (overflow)
    );

    assign signal_out = so_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed self-checking bench for pulse_train_gen.
module tb_pulse_train_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       trig = 1'b0;
    logic [7:0] high_len = 8'd1;
    logic [7:0] gap_len = 8'd1;
    logic       signal_out, busy, done, overflow;
    logic [2:0] pending;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rises = 0, falls = 0, dones = 0, ovfs = 0, coinc_err = 0;
    int rise_cyc[$];
    logic prev_so = 1'b0;

    always #5 clk = ~clk;

    pulse_train_gen #(.LEN_W(8), .PEND_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .trig       (trig),
        .high_len   (high_len),
        .gap_len    (gap_len),
        .signal_out (signal_out),
        .busy       (busy),
        .pending    (pending),
        .done       (done),
        .overflow   (overflow)
    );

    // Downstream falling-edge detector and event counters.
    always @(negedge clk) begin
        logic fall;
        fall = prev_so && !signal_out;
        if (signal_out && !prev_so) begin
            rises++;
            rise_cyc.push_back(cyc);
        end
        if (fall) falls++;
        if (done) dones++;
        if (fall != done) coinc_err++;
        if (overflow) ovfs++;
        prev_so = signal_out;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((busy || pending != 0) && n < limit) begin
            step();
            n++;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    int r0, f0, d0, o0, c0;

    initial begin
        repeat (2) step();
        chk("rst_so", int'(signal_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pend", int'(pending), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ovf", int'(overflow), 0);
        rst_n = 1'b1;
        en = 1'b1;
        step();

        // Single trigger, H=3 G=2
        high_len = 8'd3; gap_len = 8'd2; r0 = rises;
        trig = 1'b1; step(); trig = 1'b0;
        chk("t1_so0", int'(signal_out), 1);
        chk("t1_busy0", int'(busy), 1);
        step(); chk("t1_so1", int'(signal_out), 1);
        step(); chk("t1_so2", int'(signal_out), 1);
        step();
        chk("t1_so3", int'(signal_out), 0);
        chk("t1_done3", int'(done), 1);
        step();
        chk("t1_done4", int'(done), 0);
        chk("t1_busy4", int'(busy), 1);
        step(); chk("t1_busy5", int'(busy), 0);
        chk("t1_pulses", rises - r0, 1);

        // Backlog, H=2 G=1, period 3
        high_len = 8'd2; gap_len = 8'd1; r0 = rises;
        rise_cyc.delete();
        trig = 1'b1;
        step();
        step(); chk("t2_pend1", int'(pending), 1);
        step(); chk("t2_pend2", int'(pending), 2);
        step(); trig = 1'b0;
        chk("t2_pend_consume", int'(pending), 2);
        chk("t2_so_consume", int'(signal_out), 1);
        wait_idle(100);
        chk("t2_pulses", rises - r0, 4);
        chk("t2_pend_end", int'(pending), 0);
        for (int i = 1; i < 4; i++) begin
            if (rise_cyc.size() > i) chk("t2_period", rise_cyc[i] - rise_cyc[i-1], 3);
        end

        // Saturation: 9 triggers, long high phase
        high_len = 8'd20; gap_len = 8'd1; r0 = rises;
        trig = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("t3_pend", int'(pending), (i < 7) ? i : 7);
            chk("t3_ovf", int'(overflow), (i == 8) ? 1 : 0);
        end
        trig = 1'b0;
        step(); chk("t3_ovf_after", int'(overflow), 0);
        wait_idle(400);
        chk("t3_pulses", rises - r0, 8);

        // Zero lengths behave as 1
        high_len = 8'd0; gap_len = 8'd0; r0 = rises;
        trig = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 2) trig = 1'b0;
            chk("t4_so", int'(signal_out), (i % 2 == 0) ? 1 : 0);
        end
        wait_idle(50);
        chk("t4_pulses", rises - r0, 3);

        // Random loopback through falling-edge detector
        r0 = rises; f0 = falls; d0 = dones; o0 = ovfs; c0 = coinc_err;
        for (int i = 0; i < 20; i++) begin
            high_len = 8'($urandom_range(0, 3));
            gap_len = 8'($urandom_range(0, 3));
            trig = 1'b1; step(); trig = 1'b0;
            repeat ($urandom_range(0, 5)) step();
        end
        wait_idle(1000);
        step();
        chk("t5_req", (rises - r0) + (ovfs - o0), 20);
        chk("t5_falls", falls - f0, rises - r0);
        chk("t5_dones", dones - d0, rises - r0);
        chk("t5_coinc", coinc_err - c0, 0);

        // Reset mid-HIGH with two queued
        high_len = 8'd10; gap_len = 8'd2;
        trig = 1'b1;
        repeat (3) step();
        trig = 1'b0;
        chk("t6_pend", int'(pending), 2);
        chk("t6_so", int'(signal_out), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_so", int'(signal_out), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_pend", int'(pending), 0);
        step();
        rst_n = 1'b1; r0 = rises;
        repeat (10) step();
        chk("t6_no_pulse", rises - r0, 0);
        chk("t6_idle", int'(busy), 0);

        // Enable dropped mid-pulse
        high_len = 8'd4; gap_len = 8'd2; r0 = rises;
        trig = 1'b1;
        repeat (3) step();
        trig = 1'b0;
        chk("t7_pend", int'(pending), 2);
        en = 1'b0;
        step();
        chk("t7_pend_clr", int'(pending), 0);
        chk("t7_so", int'(signal_out), 1);
        repeat (20) step();
        chk("t7_pulses", rises - r0, 1);
        chk("t7_idle", int'(busy), 0);
        en = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
